// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Zero-latency helpers only; no flow control lives here.
package wb_write_arbiter_pkg;

    localparam int         REG_COUNT     = 32;
    localparam logic [4:0] ZERO_REG      = 5'd0;
    localparam int         WB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [4:0]               rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [4:0] rd);
        logic [REG_COUNT-1:0] oh;
        oh     = '0;
        oh[rd] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Sync FIFO of {rd, data} entries with a per-entry valid/rd view; head visible combinationally.
// Push while full and pop while empty are ignored; the owner gates both.
module wb_fifo #(
    parameter int  DEPTH      = 4,
    parameter int  DATA_WIDTH = 32,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [4:0]            push_rd,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           count,
    output logic [4:0]            head_rd,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [DEPTH-1:0]      ent_vld,
    output logic [DEPTH*5-1:0]    ent_rd
);

    logic [4:0]            mem_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           cnt;
    logic                  do_push;
    logic                  do_pop;
    logic [AW-1:0]         off;

    assign full      = (cnt == (AW+1)'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_rd   = mem_rd[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_rd[wr_ptr]   <= push_rd;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Slot i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        ent_vld = '0;
        ent_rd  = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off              = AW'(i) - rd_ptr;
            ent_vld[i]       = ({1'b0, off} < cnt);
            ent_rd[i*5 +: 5] = mem_rd[i];
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Sole register-file writer: pipeline writeback wins, buffered long-latency results fill idle slots, zero-cycle port select.
// Pipeline is never stalled directly; ml_ready drops only when full, stall_req asks for a bubble after STARVE_LIMIT blocked cycles.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic                     ml_valid,
    output logic                     ml_ready,
    input  logic [4:0]               ml_rd,
    input  logic [DATA_WIDTH-1:0]    ml_data,
    output logic                     write_en,
    output logic [4:0]               rsW,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic [REG_COUNT-1:0]     pend_mask,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                  full;
    logic                  empty;
    logic [$clog2(DEPTH):0] count;
    logic [4:0]            head_rd;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DEPTH-1:0]      ent_vld;
    logic [DEPTH*5-1:0]    ent_rd;
    logic                  pipe_use;
    logic                  pop;
    logic                  push;
    logic [SW-1:0]         starve_cnt;

    assign pipe_use = wb_valid && (wb_rd != ZERO_REG);
    assign pop      = !empty && !pipe_use;
    // x0 results complete the handshake but are never stored.
    assign push     = ml_valid && !full && (ml_rd != ZERO_REG);

    wb_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_rd   (ml_rd),
        .push_data (ml_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head_rd   (head_rd),
        .head_data (head_data),
        .ent_vld   (ent_vld),
        .ent_rd    (ent_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (pipe_use && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Everything is held at zero during reset, including the purely combinational paths.
    always_comb begin
        write_en   = 1'b0;
        rsW        = ZERO_REG;
        write_data = '0;
        pend_mask  = '0;
        stall_req  = 1'b0;
        fifo_count = '0;
        ml_ready   = 1'b0;
        if (rst_n) begin
            if (pipe_use) begin
                write_en   = 1'b1;
                rsW        = wb_rd;
                write_data = wb_data;
            end else if (!empty) begin
                write_en   = 1'b1;
                rsW        = head_rd;
                write_data = head_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[i]) pend_mask = pend_mask | reg_onehot(ent_rd[i*5 +: 5]);
            end
            stall_req  = (starve_cnt == SW'(STARVE_LIMIT));
            fifo_count = count;
            ml_ready   = !full;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scenario tasks plus a randomized run, all checked against a queue-based model of the writeback rules.
module tb_wb_write_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [DW-1:0]   wb_data;
    logic            ml_valid;
    logic            ml_ready;
    logic [4:0]      ml_rd;
    logic [DW-1:0]   ml_data;
    logic            write_en;
    logic [4:0]      rsW;
    logic [DW-1:0]   write_data;
    logic [31:0]     pend_mask;
    logic            stall_req;
    logic [CW-1:0]   fifo_count;

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   blocked_run = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    wb_write_arbiter #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .ml_valid   (ml_valid),
        .ml_ready   (ml_ready),
        .ml_rd      (ml_rd),
        .ml_data    (ml_data),
        .write_en   (write_en),
        .rsW        (rsW),
        .write_data (write_data),
        .pend_mask  (pend_mask),
        .stall_req  (stall_req),
        .fifo_count (fifo_count)
    );

    task automatic drive(input logic v, input logic [4:0] rd, input logic [DW-1:0] d,
                         input logic mv, input logic [4:0] mrd, input logic [DW-1:0] md);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
        ml_valid = mv;
        ml_rd    = mrd;
        ml_data  = md;
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    // Expected {write_en, rsW, write_data, pend_mask, stall_req, fifo_count, ml_ready}.
    function automatic logic [74:0] exp_vec();
        logic          pu;
        logic          we;
        logic [4:0]    rs;
        logic [DW-1:0] wd;
        logic [CW-1:0] cnt;
        if (!rst_n) return '0;
        pu  = wb_valid && (wb_rd != 5'd0);
        we  = pu || (mq.size() != 0);
        rs  = '0;
        wd  = '0;
        if (pu) begin
            rs = wb_rd;
            wd = wb_data;
        end else if (mq.size() != 0) begin
            rs = mq[0].rd;
            wd = mq[0].data;
        end
        cnt = CW'(mq.size());
        return {we, rs, wd, model_mask(), (blocked_run >= LIMIT), cnt, (mq.size() < DEPTH)};
    endfunction

    function automatic logic [74:0] obs_vec();
        return {write_en, rsW, write_data, pend_mask, stall_req, fifo_count, ml_ready};
    endfunction

    // Applies one clock edge's worth of the writeback rules to the model.
    task automatic model_clock();
        logic pu;
        logic do_pop;
        logic do_push;
        int   n;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            blocked_run = 0;
            return;
        end
        n       = mq.size();
        pu      = wb_valid && (wb_rd != 5'd0);
        do_pop  = (n > 0) && !pu;
        do_push = ml_valid && (n < DEPTH) && (ml_rd != 5'd0);
        if (n == 0 || do_pop) blocked_run = 0;
        else                  blocked_run++;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e.rd   = ml_rd;
            e.data = ml_data;
            mq.push_back(e);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            #2;
            tests++;
            if (obs_vec() !== 75'd0) begin
                fails++;
                $display("FAIL reset_zero cyc=%0d got=%h exp=0", c, obs_vec());
            end
            advance();
        end
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        tests++;
        if (fifo_count !== '0 || ml_ready !== 1'b1 || write_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got cnt=%0d rdy=%b we=%b exp cnt=0 rdy=1 we=0", fifo_count, ml_ready, write_en);
        end
        advance();
    endtask

    task automatic test_idle_drain();
        int pend5 = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
            else        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            #2;
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL idle_drain_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (pend_mask[5]) pend5++;
            if (c == 1) begin
                tests++;
                if (write_en !== 1'b1 || rsW !== 5'd5 || write_data !== 32'hDEADBEEF) begin
                    fails++;
                    $display("FAIL idle_drain_write got we=%b rd=%0d d=%h exp we=1 rd=5 d=deadbeef", write_en, rsW, write_data);
                end
            end
            advance();
        end
        tests++;
        if (pend5 != 1) begin
            fails++;
            $display("FAIL idle_drain_pend_cycles got=%0d exp=1", pend5);
        end
    endtask

    task automatic test_priority();
        for (int c = 0; c < 7; c++) begin
            if (c == 0)     drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
            else if (c < 5) drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
            else            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            #2;
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL priority_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c >= 1 && c < 5) begin
                tests++;
                if (rsW !== 5'd3 || write_data !== 32'h11 || fifo_count !== CW'(1)) begin
                    fails++;
                    $display("FAIL priority_pipe cyc=%0d got rd=%0d d=%h cnt=%0d exp rd=3 d=11 cnt=1", c, rsW, write_data, fifo_count);
                end
            end
            if (c == 5) begin
                tests++;
                if (write_en !== 1'b1 || rsW !== 5'd7 || write_data !== 32'h22) begin
                    fails++;
                    $display("FAIL priority_drain got we=%b rd=%0d d=%h exp we=1 rd=7 d=22", write_en, rsW, write_data);
                end
            end
            advance();
        end
    endtask

    task automatic test_full();
        for (int c = 0; c < 6; c++) begin
            if (c < 5) drive(1'b1, 5'd3, 32'h11, 1'b1, 5'(10 + c), 32'h100 + 32'(c));
            else       drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
            #2;
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL full_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c >= 4) begin
                tests++;
                if (ml_ready !== 1'b0 || fifo_count !== CW'(4)) begin
                    fails++;
                    $display("FAIL full_backpressure cyc=%0d got rdy=%b cnt=%0d exp rdy=0 cnt=4", c, ml_ready, fifo_count);
                end
            end
            advance();
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            #2;
            tests++;
            if (c < 4) begin
                if (write_en !== 1'b1 || rsW !== 5'(10 + c) || write_data !== 32'h100 + 32'(c)) begin
                    fails++;
                    $display("FAIL full_order cyc=%0d got we=%b rd=%0d d=%h exp we=1 rd=%0d d=%h",
                             c, write_en, rsW, write_data, 10 + c, 32'h100 + 32'(c));
                end
            end else if (ml_ready !== 1'b1 || write_en !== 1'b0) begin
                fails++;
                $display("FAIL full_release got rdy=%b we=%b exp rdy=1 we=0", ml_ready, write_en);
            end
            advance();
        end
    endtask

    task automatic test_x0();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0:       drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hAA);
                2:       drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
                3:       drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
                default: drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            endcase
            #2;
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL x0_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c == 1) begin
                tests++;
                if (fifo_count !== '0 || write_en !== 1'b0 || ml_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL x0_discard got cnt=%0d we=%b rdy=%b exp cnt=0 we=0 rdy=1", fifo_count, write_en, ml_ready);
                end
            end
            if (c == 3) begin
                tests++;
                if (write_en !== 1'b1 || rsW !== 5'd9 || write_data !== 32'h99) begin
                    fails++;
                    $display("FAIL x0_pipe_zero got we=%b rd=%0d d=%h exp we=1 rd=9 d=99", write_en, rsW, write_data);
                end
            end
            advance();
        end
    endtask

    task automatic test_starvation();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0FFEE);
        #2;
        advance();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 5'd4, 32'(k), 1'b0, 5'd0, 32'd0);
            #2;
            tests++;
            if (stall_req !== (k > LIMIT) || obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL starve_ramp blocked=%0d got stall=%b vec=%h exp stall=%b vec=%h",
                         k, stall_req, obs_vec(), (k > LIMIT), exp_vec());
            end
            advance();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        tests++;
        if (write_en !== 1'b1 || rsW !== 5'd12 || write_data !== 32'hC0FFEE || stall_req !== 1'b1) begin
            fails++;
            $display("FAIL starve_bubble got we=%b rd=%0d d=%h stall=%b exp we=1 rd=12 d=c0ffee stall=1",
                     write_en, rsW, write_data, stall_req);
        end
        advance();
        #2;
        tests++;
        if (stall_req !== 1'b0 || fifo_count !== '0) begin
            fails++;
            $display("FAIL starve_clear got stall=%b cnt=%0d exp stall=0 cnt=0", stall_req, fifo_count);
        end
        advance();
    endtask

    task automatic test_reset_mid_drain();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'd3, 32'h33, 1'b1, 5'(20 + c), 32'h200 + 32'(c));
            #2;
            advance();
        end
        rst_n = 1'b0;
        #2;
        tests++;
        if (fifo_count !== '0 || pend_mask !== '0 || write_en !== 1'b0 || ml_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid got cnt=%0d pend=%h we=%b rdy=%b exp all 0", fifo_count, pend_mask, write_en, ml_ready);
        end
        advance();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            #2;
            tests++;
            if (write_en !== 1'b0 || fifo_count !== '0) begin
                fails++;
                $display("FAIL reset_mid_after cyc=%0d got we=%b rd=%0d cnt=%0d exp we=0 cnt=0", c, write_en, rsW, fifo_count);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [4:0]  rd;
        logic [31:0] m;
        int          busy_pct;
        for (int c = 0; c < 2000; c++) begin
            rst_n    = ($urandom_range(0, 399) != 0);
            busy_pct = ((c / 100) % 2 == 0) ? 90 : 25;
            m        = model_mask();
            v        = ($urandom_range(0, 99) < busy_pct);
            rd       = 5'($urandom_range(0, 31));
            if (m[rd]) v = 1'b0;
            drive(v, rd, $urandom, ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            #2;
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        test_reset();
        test_idle_drain();
        test_priority();
        test_full();
        test_x0();
        test_starvation();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
